// File: rtl/instr_fetch.sv
// Fetch stage of the 19-bit CPU: owns the PC, drives instmem's synchronous read
// port and registers the returned word for decode. Handles stall, branch flush and HALT.
module instr_fetch #(
  parameter int AW = 14,
  parameter int DW = 19,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int OPW = 5,
  parameter logic [OPW-1:0] HALT_OP = 5'h1F
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  output logic [AW-1:0] addIM,
  input  logic [DW-1:0] outIM,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] pc_out,
  output logic          instr_valid,
  output logic          halted
);

  // Handshake: instr/pc_out are meaningful only while instr_valid=1. Decode
  // applies back-pressure with stall; branch_taken is a single-cycle request
  // that is always accepted in RUN and ignored in HALT.
  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] pend_pc_q, pend_pc_d;
  logic          pend_valid_q, pend_valid_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [AW-1:0] pc_out_q, pc_out_d;
  logic          instr_valid_q, instr_valid_d;
  logic          advance;
  logic          is_halt_word;

  assign advance      = (state_q == S_RUN) && !branch_taken && !stall;
  assign is_halt_word = pend_valid_q && (outIM[DW-1:DW-OPW] == HALT_OP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RUN;
      fetch_pc_q    <= RESET_PC;
      pend_pc_q     <= '0;
      pend_valid_q  <= 1'b0;
      instr_q       <= '0;
      pc_out_q      <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pend_pc_q     <= pend_pc_d;
      pend_valid_q  <= pend_valid_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (advance && is_halt_word) state_d = S_HALT;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    pend_pc_d     = pend_pc_q;
    pend_valid_d  = pend_valid_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      S_RUN: begin
        if (branch_taken) begin
          // Flush both the in-flight read and the presented instruction.
          fetch_pc_d    = branch_target;
          pend_valid_d  = 1'b0;
          instr_valid_d = 1'b0;
        end else if (!stall) begin
          fetch_pc_d    = fetch_pc_q + 1'b1;
          pend_pc_d     = fetch_pc_q;
          pend_valid_d  = 1'b1;
          instr_d       = outIM;
          pc_out_d      = pend_pc_q;
          instr_valid_d = pend_valid_q;
        end
      end
      S_HALT: begin
        pend_valid_d  = 1'b0;
        instr_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // During a stall the in-flight address is re-issued so outIM stays put.
  assign addIM       = ((state_q == S_RUN) && stall && !branch_taken) ? pend_pc_q : fetch_pc_q;
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = instr_valid_q;
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: synchronous instmem model feeding two DUTs (RESET_PC=0
// and RESET_PC=14'h3FFE) and a stream-level model of the expected fetch order.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_taken;
  logic [13:0] branch_target;
  logic [13:0] addIM, pc_out, addIM2, pc_out2;
  logic [18:0] outIM, instr, outIM2, instr2;
  logic        instr_valid, halted, instr_valid2, halted2;

  logic [18:0] mem [0:16383];
  logic [18:0] exp_q[$];

  int tests_run = 0;
  int tests_failed = 0;

  // Stream model: next address to be presented, invalid edges still owed
  // before it appears, and the currently presented instruction.
  logic [13:0] m_next;
  int          m_warm;
  logic        m_valid, m_halted;
  logic [18:0] m_instr;
  logic [13:0] m_pc;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    outIM  <= mem[addIM];
    outIM2 <= mem[addIM2];
  end

  instr_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .addIM(addIM), .outIM(outIM), .instr(instr),
    .pc_out(pc_out), .instr_valid(instr_valid), .halted(halted)
  );

  instr_fetch #(.RESET_PC(14'h3FFE)) dut2 (
    .clk(clk), .rst(rst), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(14'h0000), .addIM(addIM2), .outIM(outIM2), .instr(instr2),
    .pc_out(pc_out2), .instr_valid(instr_valid2), .halted(halted2)
  );

  task automatic fill_mem();
    logic [18:0] w;
    for (int i = 0; i < 16384; i++) begin
      w = 19'($urandom);
      if (w[18:14] == 5'h1F) w[18] = 1'b0;
      mem[i] = w;
    end
  endtask

  task automatic model_init(input logic [13:0] start_pc);
    m_next = start_pc; m_warm = 1; m_valid = 1'b0; m_halted = 1'b0;
    m_instr = '0; m_pc = '0;
  endtask

  task automatic model_edge(input logic s, input logic b, input logic [13:0] t);
    if (m_halted) begin
      m_valid = 1'b0;
    end else if (b) begin
      m_next = t; m_warm = 1; m_valid = 1'b0;
    end else if (!s) begin
      if (m_warm > 0) begin
        m_warm--; m_valid = 1'b0;
      end else begin
        m_valid = 1'b1; m_pc = m_next; m_instr = mem[m_next];
        m_next = m_next + 14'd1;
        if (m_instr[18:14] == 5'h1F) m_halted = 1'b1;
      end
    end
  endtask

  // Applies inputs for one cycle, advances the model at the edge, returns at negedge.
  task automatic step(input logic s, input logic b, input logic [13:0] t);
    stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    model_edge(s, b, t);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [13:0] start_pc);
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_init(start_pc);
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({addIM, instr, pc_out, instr_valid, halted} !== {14'h0, 19'h0, 14'h0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset: addIM=%h instr=%h pc=%h valid=%b halted=%b, expected all zero",
               addIM, instr, pc_out, instr_valid, halted);
    end
    tests_run++;
    if (addIM2 !== 14'h3FFE) begin
      tests_failed++;
      $display("FAIL reset_pc2: addIM=%h expected 3ffe", addIM2);
    end
    rst = 1'b0;
    model_init(14'h0);
  endtask

  task automatic test_stream();
    fill_mem();
    mem[0] = 19'h00381; mem[1] = 19'h00234; mem[2] = 19'h00001; mem[3] = 19'h00002;
    exp_q = {19'h00381, 19'h00234, 19'h00001, 19'h00002};
    do_reset(14'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 14'h0);
      tests_run++;
      if (instr_valid !== (i >= 1)) begin
        tests_failed++;
        $display("FAIL stream_valid[%0d]: got %b expected %b", i, instr_valid, (i >= 1));
      end
      if (instr_valid === 1'b1 && exp_q.size() > 0) begin
        tests_run++;
        if (instr !== exp_q[0] || pc_out !== 14'(i - 1)) begin
          tests_failed++;
          $display("FAIL stream_word[%0d]: instr=%h pc=%h expected instr=%h pc=%h",
                   i, instr, pc_out, exp_q[0], 14'(i - 1));
        end
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_stall();
    fill_mem();
    do_reset(14'h0);
    repeat (3) step(1'b0, 1'b0, 14'h0);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      #1;
      tests_run++;
      if (addIM !== 14'd2) begin
        tests_failed++;
        $display("FAIL stall_addr[%0d]: addIM=%h expected 0002", i, addIM);
      end
      step(1'b1, 1'b0, 14'h0);
      tests_run++;
      if (instr_valid !== 1'b1 || instr !== mem[1] || pc_out !== 14'd1) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: valid=%b instr=%h pc=%h expected 1 %h 0001",
                 i, instr_valid, instr, pc_out, mem[1]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 14'h0);
      tests_run++;
      if (instr_valid !== 1'b1 || instr !== mem[2 + i] || pc_out !== 14'(2 + i)) begin
        tests_failed++;
        $display("FAIL stall_release[%0d]: valid=%b instr=%h pc=%h expected 1 %h %h",
                 i, instr_valid, instr, pc_out, mem[2 + i], 14'(2 + i));
      end
    end
  endtask

  task automatic test_branch(input logic with_stall, input logic [13:0] tgt);
    fill_mem();
    do_reset(14'h0);
    repeat (4) step(1'b0, 1'b0, 14'h0);
    step(with_stall, 1'b1, tgt);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (instr_valid !== (i >= 2) || (i >= 2 && (pc_out !== tgt + 14'(i - 2) ||
          instr !== mem[tgt + 14'(i - 2)]))) begin
        tests_failed++;
        $display("FAIL branch%0s[%0d]: valid=%b pc=%h instr=%h expected valid=%b pc=%h",
                 with_stall ? "_stall" : "", i, instr_valid, pc_out, instr, (i >= 2),
                 tgt + 14'(i - 2));
      end
      step(1'b0, 1'b0, 14'h0);
    end
  endtask

  task automatic test_halt();
    fill_mem();
    mem[5] = 19'h7C000;
    do_reset(14'h0);
    repeat (7) step(1'b0, 1'b0, 14'h0);
    tests_run++;
    if (instr_valid !== 1'b1 || pc_out !== 14'd5 || instr !== 19'h7C000) begin
      tests_failed++;
      $display("FAIL halt_present: valid=%b pc=%h instr=%h expected 1 0005 7c000",
               instr_valid, pc_out, instr);
    end
    for (int i = 0; i < 4; i++) begin
      step(i[0], 1'b1, 14'h0100);
      #1;
      tests_run++;
      if (instr_valid !== 1'b0 || halted !== 1'b1 || addIM !== 14'd7) begin
        tests_failed++;
        $display("FAIL halt_frozen[%0d]: valid=%b halted=%b addIM=%h expected 0 1 0007",
                 i, instr_valid, halted, addIM);
      end
    end
    do_reset(14'h0);
    tests_run++;
    if (halted !== 1'b0 || instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_reset: halted=%b valid=%b expected 0 0", halted, instr_valid);
    end
  endtask

  task automatic test_branch_beats_halt();
    fill_mem();
    mem[5] = 19'h7C123;
    do_reset(14'h0);
    repeat (6) step(1'b0, 1'b0, 14'h0);
    step(1'b0, 1'b1, 14'h0040);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (halted !== 1'b0 || instr_valid !== m_valid || (m_valid && pc_out !== m_pc)) begin
        tests_failed++;
        $display("FAIL branch_over_halt[%0d]: halted=%b valid=%b pc=%h expected 0 %b %h",
                 i, halted, instr_valid, pc_out, m_valid, m_pc);
      end
      step(1'b0, 1'b0, 14'h0);
    end
  endtask

  task automatic test_random();
    logic s, b;
    logic [13:0] t;
    fill_mem();
    do_reset(14'h0);
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 9) == 0);
      t = 14'($urandom);
      stall = s; branch_taken = b; branch_target = t;
      #1;
      if (s && !b && m_warm == 0) begin
        tests_run++;
        if (addIM !== m_next) begin
          tests_failed++;
          $display("FAIL random_addr[%0d]: addIM=%h expected %h", i, addIM, m_next);
        end
      end
      step(s, b, t);
      tests_run++;
      if (instr_valid !== m_valid || halted !== m_halted ||
          (m_valid && (instr !== m_instr || pc_out !== m_pc))) begin
        tests_failed++;
        $display("FAIL random[%0d]: valid=%b halted=%b instr=%h pc=%h expected %b %b %h %h",
                 i, instr_valid, halted, instr, pc_out, m_valid, m_halted, m_instr, m_pc);
      end
    end
  endtask

  task automatic test_wrap();
    logic [13:0] exp_pc;
    fill_mem();
    do_reset(14'h0);
    exp_pc = 14'h3FFE;
    step(1'b0, 1'b0, 14'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 14'h0);
      tests_run++;
      if (instr_valid2 !== 1'b1 || pc_out2 !== exp_pc || instr2 !== mem[exp_pc]) begin
        tests_failed++;
        $display("FAIL wrap[%0d]: valid=%b pc=%h instr=%h expected 1 %h %h",
                 i, instr_valid2, pc_out2, instr2, exp_pc, mem[exp_pc]);
      end
      exp_pc = exp_pc + 14'd1;
    end
  endtask

  task automatic test_async_reset();
    fill_mem();
    do_reset(14'h0);
    repeat (5) step(1'b0, 1'b0, 14'h0);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({addIM, instr, pc_out, instr_valid, halted} !== {14'h0, 19'h0, 14'h0, 1'b0, 1'b0} ||
        {addIM2, instr_valid2, pc_out2} !== {14'h3FFE, 1'b0, 14'h0}) begin
      tests_failed++;
      $display("FAIL async_reset: addIM=%h instr=%h pc=%h valid=%b halted=%b addIM2=%h valid2=%b",
               addIM, instr, pc_out, instr_valid, halted, addIM2, instr_valid2);
    end
    @(negedge clk);
    rst = 1'b0;
    model_init(14'h0);
    repeat (2) step(1'b0, 1'b0, 14'h0);
    tests_run++;
    if (instr_valid !== 1'b1 || pc_out !== 14'h0 || instr !== mem[0]) begin
      tests_failed++;
      $display("FAIL async_restart: valid=%b pc=%h instr=%h expected 1 0000 %h",
               instr_valid, pc_out, instr, mem[0]);
    end
  endtask

  initial begin
    fill_mem();
    test_reset();
    test_stream();
    test_stall();
    test_branch(1'b0, 14'h0100);
    test_branch(1'b1, 14'h0200);
    test_halt();
    test_branch_beats_halt();
    test_random();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the 19-bit CPU. Sits directly upstream of instmem.
- Holds the program counter and drives instmem's read address addIM.
- Captures the returned word outIM into an instruction register with a valid flag for decode.
- Supports decode stall, branch redirect with flush, and halt on a HALT opcode.

Parameters:
AW, 14, address/PC width (matches addIM)
DW, 19, instruction width (matches outIM)
RESET_PC, 0, PC value loaded on reset
OPW, 5, opcode field width, taken from instr[DW-1:DW-OPW]
HALT_OP, 5'h1F, opcode value that halts fetch

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  decode cannot accept; freeze fetch
branch_taken  input  1  one-cycle redirect request
branch_target  input  AW  redirect address
addIM  output  AW  read address to instmem
outIM  input  DW  instmem read data, synchronous read: reflects mem[addIM] sampled at the previous edge
instr  output  DW  registered instruction to decode
pc_out  output  AW  address of instr
instr_valid  output  1  instr/pc_out hold a valid instruction
halted  output  1  fetch stopped by HALT

Behaviour:
Clock and reset:
- One clock. rst is asynchronous, active-high.
- While rst=1: fetch_pc=RESET_PC, pend_pc=0, pend_valid=0, instr=0, pc_out=0, instr_valid=0, halted=0, state=RUN.

Internal registers:
- fetch_pc: next address to issue.
- pend_pc / pend_valid: address in flight inside instmem.
- States: RUN, HALT.

addIM (combinational):
- pend_pc when state=RUN and stall=1 and branch_taken=0. Re-reads the in-flight address so outIM stays stable.
- fetch_pc otherwise.

RUN, per edge, in priority order:
1. branch_taken=1 (wins over stall): fetch_pc<=branch_target; pend_valid<=0; instr_valid<=0. instr and pc_out hold their values.
2. stall=1: all registers hold.
3. Otherwise:
   - fetch_pc<=fetch_pc+1; wraps 14'h3FFF->0, no flag.
   - pend_pc<=fetch_pc; pend_valid<=1.
   - instr<=outIM; pc_out<=pend_pc; instr_valid<=pend_valid.
   - If pend_valid=1 and outIM[DW-1:DW-OPW]==HALT_OP: state<=HALT, halted<=1.

Latency:
- A new address appears on addIM; its word is registered into instr at the second following edge.
- After reset, the first instr_valid rises after the 2nd edge.
- After a branch edge, instr_valid is low for exactly 2 cycles, then the target word appears with pc_out=branch_target.
- In steady streaming there is 1 instruction per cycle with no bubbles.

HALT:
- The HALT instruction itself is presented with instr_valid=1 for one cycle.
- At the next edge: instr_valid<=0 and pend_valid<=0; fetch_pc frozen; addIM=fetch_pc.
- stall and branch_taken are ignored. Only rst exits HALT.

Boundaries:
- Stall released: resumes with the next sequential word, no duplicate and no skip.
- Branch during stall: the stalled instruction is dropped.
- Branch on the edge that registers a HALT: branch wins, no halt.
- rst mid-stream: immediate return to reset values; in-flight data is discarded.
- Fetch never writes instmem; we_IM is owned by the loader and must be 0 while fetch runs.

Test Plan:
1. Reset with mem[0..3]=19'h00381, 19'h00234, 19'h00001, 19'h00002; stall=0.
   -> instr_valid rises after 2nd edge: instr=19'h00381, pc_out=0; then 19'h00234/1, 19'h00001/2 on consecutive cycles.
2. Hold stall=1 for 3 cycles while instr=mem[1].
   -> instr, pc_out, instr_valid unchanged; addIM=2 during stall; after release the next instr is mem[2] with pc_out=2, no duplicate.
3. branch_taken=1, branch_target=14'h0100, on the edge where pc_out=2.
   -> instr_valid=0 for 2 cycles, then pc_out=14'h0100, instr=mem[0x100], continuing with 0x101.
4. branch_taken=1 and stall=1 in the same cycle.
   -> branch wins; same timing as scenario 3.
5. mem[5]=19'h7C000 (opcode 5'h1F).
   -> pc_out=5 presented with instr_valid=1, then instr_valid=0 and halted=1; addIM frozen; a later branch_taken pulse has no effect; rst clears halted.
6. RESET_PC=14'h3FFE.
   -> pc_out sequence 14'h3FFE, 14'h3FFF, 14'h0000. Then assert rst asynchronously mid-cycle -> all outputs go to reset values before the next edge.
